// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: widths, op codes,
// divide-by-zero LO value and a conditional-negate helper.
package mul_div_unit_pkg;

   localparam int unsigned DATA_WIDTH = 32;
   localparam int unsigned OP_W       = 3;

   typedef enum logic [OP_W-1:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5
   } mdu_op_e;

   localparam logic [DATA_WIDTH-1:0] DIV0_LO = '1;

   // Two's-complement negate when neg is set; also used to take magnitudes.
   function automatic logic [DATA_WIDTH-1:0] cond_neg(input logic [DATA_WIDTH-1:0] x,
                                                      input logic                  neg);
      return neg ? -x : x;
   endfunction

endpackage

// File: rtl/mul_div_unit_step.sv
// One radix-2 iteration: shift-add multiply on {acc, mplier} or restoring
// shift-subtract divide on {rem, quot}, selected by is_div.
module mul_div_unit_step
   import mul_div_unit_pkg::*;
(
   input  logic                    is_div,
   input  logic [2*DATA_WIDTH-1:0] work,
   input  logic [DATA_WIDTH-1:0]   opb,
   output logic [2*DATA_WIDTH-1:0] work_next_c
);

   localparam int unsigned W = DATA_WIDTH;

   logic [W:0]   sum;
   logic [W:0]   rem_sh;
   logic [W-1:0] diff;
   logic         fits;

   always_comb begin
      sum    = {1'b0, work[2*W-1:W]} + (work[0] ? {1'b0, opb} : '0);
      rem_sh = work[2*W-1:W-1];
      fits   = rem_sh >= {1'b0, opb};
      // Modular W-bit subtract is exact whenever the divisor fits.
      diff   = rem_sh[W-1:0] - opb;
      if (!is_div) begin
         work_next_c = {sum, work[W-1:1]};
      end else if (fits) begin
         work_next_c = {diff, work[W-2:0], 1'b1};
      end else begin
         work_next_c = {rem_sh[W-1:0], work[W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU in
// 32 radix-2 iterations plus a sign-fix cycle, handles MTHI/MTLO in one cycle.
module mul_div_unit
   import mul_div_unit_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [OP_W-1:0]       op,
   input  logic [DATA_WIDTH-1:0] rs_val,
   input  logic [DATA_WIDTH-1:0] rt_val,
   input  logic                  flush,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] hi,
   output logic [DATA_WIDTH-1:0] lo
);

   localparam int unsigned W     = DATA_WIDTH;
   localparam int unsigned CNT_W = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

   state_e           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2*W-1:0]   work, work_n, step_c;
   logic [W-1:0]     opb, opb_n;
   logic             is_div, is_div_n;
   logic             neg_q, neg_q_n;
   logic             neg_r, neg_r_n;
   logic             div0, div0_n;
   logic             busy_n, done_n;
   logic [W-1:0]     hi_n, lo_n;

   logic             op_div_c, is_muldiv_c, signed_op_c, sa_c, sb_c;
   logic [W-1:0]     mag_a_c, mag_b_c;
   logic [2*W-1:0]   prod_c;
   logic [W-1:0]     quot_c, rem_c;

   // Issue decode and operand magnitudes.
   assign op_div_c    = (op == MDU_DIV) || (op == MDU_DIVU);
   assign is_muldiv_c = (op == MDU_MULT) || (op == MDU_MULTU) || op_div_c;
   assign signed_op_c = (op == MDU_MULT) || (op == MDU_DIV);
   assign sa_c        = signed_op_c & rs_val[W-1];
   assign sb_c        = signed_op_c & rt_val[W-1];
   assign mag_a_c     = cond_neg(rs_val, sa_c);
   assign mag_b_c     = cond_neg(rt_val, sb_c);

   // Sign correction applied in FIX.
   assign prod_c = neg_q ? -work : work;
   assign quot_c = cond_neg(work[W-1:0], neg_q);
   assign rem_c  = cond_neg(work[2*W-1:W], neg_r);

   mul_div_unit_step u_step (
      .is_div      (is_div),
      .work        (work),
      .opb         (opb),
      .work_next_c (step_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         work   <= '0;
         opb    <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         div0   <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         work   <= work_n;
         opb    <= opb_n;
         is_div <= is_div_n;
         neg_q  <= neg_q_n;
         neg_r  <= neg_r_n;
         div0   <= div0_n;
         busy   <= busy_n;
         done   <= done_n;
         hi     <= hi_n;
         lo     <= lo_n;
      end
   end

   // Next state, datapath update and registered outputs.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      work_n   = work;
      opb_n    = opb;
      is_div_n = is_div;
      neg_q_n  = neg_q;
      neg_r_n  = neg_r;
      div0_n   = div0;
      busy_n   = 1'b0;
      done_n   = 1'b0;
      hi_n     = hi;
      lo_n     = lo;

      unique case (state)
         IDLE: begin
            if (start && !flush) begin
               if (is_muldiv_c) begin
                  is_div_n = op_div_c;
                  neg_q_n  = sa_c ^ sb_c;
                  neg_r_n  = sa_c;
                  div0_n   = op_div_c && (rt_val == '0);
                  // Divide keeps the dividend in the low half; multiply the multiplier.
                  work_n   = {{W{1'b0}}, (op_div_c ? mag_a_c : mag_b_c)};
                  opb_n    = op_div_c ? mag_b_c : mag_a_c;
                  cnt_n    = CNT_W'(W - 1);
                  state_n  = CALC;
               end else if (op == MDU_MTHI) begin
                  hi_n = rs_val;
               end else if (op == MDU_MTLO) begin
                  lo_n = rs_val;
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_n = IDLE;
            end else begin
               busy_n = 1'b1;
               // Counter MSB sets once all W iterations have been applied.
               if (!cnt[CNT_W-1]) begin
                  work_n = step_c;
                  cnt_n  = cnt - CNT_W'(1);
               end else begin
                  state_n = FIX;
               end
            end
         end
         FIX: begin
            state_n = IDLE;
            if (!flush) begin
               done_n = 1'b1;
               if (is_div) begin
                  hi_n = rem_c;
                  lo_n = div0 ? DIV0_LO : quot_c;
               end else begin
                  hi_n = prod_c[2*W-1:W];
                  lo_n = prod_c[W-1:0];
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule
